// File: rtl/key_pkg.sv
// Shared types and constants for the key/challenge PAL unlock sequencer.
// Holds the FSM state encoding, the key window decode and the select/deselect drive patterns.
package key_pkg;

   localparam int unsigned DEF_MAX_STEPS = 16;
   localparam int unsigned NIB_W         = 4;

   localparam logic KEY_WIN_BA13 = 1'b0;
   localparam logic KEY_WIN_BA12 = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_FLUSH = 3'd2,
      ST_BURST = 3'd3,
      ST_FIN   = 3'd4
   } state_e;

   typedef struct packed {
      logic             sser;
      logic             ba13;
      logic             ba12;
      logic             br_w;
      logic [NIB_W-1:0] ba7_4;
   } key_drive_t;

   // Deselected drive: SSER high and outside the key window, so the PAL clears to state 0.
   localparam key_drive_t KEY_DESEL = key_drive_t'({1'b1, 1'b1, 1'b0, 1'b0, 4'h0});

   function automatic key_drive_t key_select(input logic [NIB_W-1:0] nib);
      key_drive_t d;
      d.sser  = 1'b0;
      d.ba13  = KEY_WIN_BA13;
      d.ba12  = KEY_WIN_BA12;
      d.br_w  = 1'b1;
      d.ba7_4 = nib;
      return d;
   endfunction

endpackage

// File: rtl/key_bus_drive.sv
// Registered select/address driver for the key PAL window.
// force_desel overrides the registered drive combinationally so a lost grant releases the bus at once.
module key_bus_drive
   import key_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             sel_nxt,
   input  logic [NIB_W-1:0] nib_nxt,
   input  logic             force_desel,
   output logic             key_sser,
   output logic             key_ba13,
   output logic             key_ba12,
   output logic [NIB_W-1:0] key_ba7_4,
   output logic             key_br_w
);

   key_drive_t drv_q;
   key_drive_t drv_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         drv_q <= KEY_DESEL;
      end else if (sel_nxt) begin
         drv_q <= key_select(nib_nxt);
      end else begin
         drv_q <= KEY_DESEL;
      end
   end

   always_comb begin
      drv_c = drv_q;
      if (force_desel) begin
         drv_c = KEY_DESEL;
      end
   end

   assign key_sser  = drv_c.sser;
   assign key_ba13  = drv_c.ba13;
   assign key_ba12  = drv_c.ba12;
   assign key_ba7_4 = drv_c.ba7_4;
   assign key_br_w  = drv_c.br_w;

endmodule

// File: rtl/key_unlock_sequencer.sv
// Bus-side controller that flushes the key PAL, plays a nibble sequence with select held,
// collects the key data bit per step and compares it against an expected pattern.
module key_unlock_sequencer
   import key_pkg::*;
#(
   parameter int unsigned MAX_STEPS   = DEF_MAX_STEPS,
   parameter int unsigned GNT_TIMEOUT = 255
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [$clog2(MAX_STEPS+1)-1:0]   num_steps,
   input  logic [NIB_W*MAX_STEPS-1:0]       nib_seq,
   // expected key bit per step ("expect" itself is a reserved word)
   input  logic [MAX_STEPS-1:0]             expect_bits,
   output logic                             bus_req,
   input  logic                             bus_gnt,
   output logic                             key_sser,
   output logic                             key_ba13,
   output logic                             key_ba12,
   output logic [NIB_W-1:0]                 key_ba7_4,
   output logic                             key_br_w,
   input  logic                             key_d,
   output logic                             busy,
   output logic                             done,
   output logic                             pass,
   output logic                             err,
   output logic [MAX_STEPS-1:0]             resp
);

   localparam int unsigned CNT_W = $clog2(MAX_STEPS + 1);
   localparam int unsigned IDX_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
   localparam int unsigned TMO_W = $clog2(GNT_TIMEOUT + 1);
   localparam int unsigned SEQ_W = NIB_W * MAX_STEPS;

   state_e               state_q, state_nxt;
   logic [CNT_W-1:0]     step_q, step_nxt;
   logic [CNT_W-1:0]     num_q, num_nxt;
   logic [TMO_W-1:0]     tmo_q, tmo_nxt;
   logic [SEQ_W-1:0]     nibs_q, nibs_nxt;
   logic [MAX_STEPS-1:0] exp_q, exp_nxt;
   logic [MAX_STEPS-1:0] resp_nxt;
   logic                 err_nxt;
   logic                 pass_nxt;
   logic [MAX_STEPS-1:0] step_mask;
   logic [NIB_W-1:0]     nib_arr [MAX_STEPS];
   logic                 sel_nxt;
   logic [NIB_W-1:0]     nib_drv;
   logic                 force_desel_c;

   // Only the first num_q response bits take part in the compare.
   always_comb begin
      for (int i = 0; i < int'(MAX_STEPS); i++) begin
         step_mask[i] = (CNT_W'(i) < num_q);
         nib_arr[i]   = nibs_q[NIB_W*i +: NIB_W];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         num_q   <= '0;
         tmo_q   <= '0;
         nibs_q  <= '0;
         exp_q   <= '0;
         resp    <= '0;
         err     <= 1'b0;
         pass    <= 1'b0;
         bus_req <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_nxt;
         step_q  <= step_nxt;
         num_q   <= num_nxt;
         tmo_q   <= tmo_nxt;
         nibs_q  <= nibs_nxt;
         exp_q   <= exp_nxt;
         resp    <= resp_nxt;
         err     <= err_nxt;
         pass    <= pass_nxt;
         bus_req <= (state_nxt == ST_REQ) || (state_nxt == ST_FLUSH) || (state_nxt == ST_BURST);
         busy    <= (state_nxt != ST_IDLE);
         done    <= (state_nxt == ST_FIN);
      end
   end

   always_comb begin
      state_nxt = state_q;
      step_nxt  = step_q;
      num_nxt   = num_q;
      tmo_nxt   = tmo_q;
      nibs_nxt  = nibs_q;
      exp_nxt   = exp_q;
      resp_nxt  = resp;
      err_nxt   = err;
      pass_nxt  = pass;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_nxt   = (num_steps > CNT_W'(MAX_STEPS)) ? CNT_W'(MAX_STEPS) : num_steps;
               nibs_nxt  = nib_seq;
               exp_nxt   = expect_bits;
               resp_nxt  = '0;
               err_nxt   = 1'b0;
               pass_nxt  = 1'b0;
               tmo_nxt   = '0;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (bus_gnt) begin
               state_nxt = ST_FLUSH;
            end else if (tmo_q == TMO_W'(GNT_TIMEOUT - 1)) begin
               err_nxt   = 1'b1;
               state_nxt = ST_FIN;
            end else begin
               tmo_nxt = tmo_q + TMO_W'(1);
            end
         end
         ST_FLUSH: begin
            if (!bus_gnt) begin
               err_nxt   = 1'b1;
               state_nxt = ST_FIN;
            end else if (num_q == '0) begin
               state_nxt = ST_FIN;
            end else begin
               step_nxt  = '0;
               state_nxt = ST_BURST;
            end
         end
         ST_BURST: begin
            // A lost grant aborts without sampling: the step never completed on the key.
            if (!bus_gnt) begin
               err_nxt   = 1'b1;
               state_nxt = ST_FIN;
            end else begin
               resp_nxt[IDX_W'(step_q)] = key_d;
               if (step_q == num_q - CNT_W'(1)) begin
                  state_nxt = ST_FIN;
               end else begin
                  step_nxt = step_q + CNT_W'(1);
               end
            end
         end
         ST_FIN: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      // Verdict is registered on entry to FIN so it is valid together with done.
      if (state_nxt == ST_FIN) begin
         pass_nxt = ~err_nxt & (((resp_nxt ^ exp_nxt) & step_mask) == '0);
      end
   end

   assign sel_nxt       = (state_nxt == ST_BURST);
   assign nib_drv       = nib_arr[IDX_W'(step_nxt)];
   assign force_desel_c = ((state_q == ST_FLUSH) || (state_q == ST_BURST)) && !bus_gnt;

   key_bus_drive u_drive (
      .clk         (clk),
      .rst         (rst),
      .sel_nxt     (sel_nxt),
      .nib_nxt     (nib_drv),
      .force_desel (force_desel_c),
      .key_sser    (key_sser),
      .key_ba13    (key_ba13),
      .key_ba12    (key_ba12),
      .key_ba7_4   (key_ba7_4),
      .key_br_w    (key_br_w)
   );

endmodule

// File: tb/tb_key_unlock_sequencer.sv
// Directed bench for key_unlock_sequencer: a vector table of complete runs against a
// behavioural key PAL, plus hand sequences for reset values and reset mid-burst.
module tb_key_unlock_sequencer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [4:0]  num_steps;
   logic [63:0] nib_seq;
   logic [15:0] expect_bits;
   logic        bus_req;
   logic        bus_gnt;
   logic        key_sser;
   logic        key_ba13;
   logic        key_ba12;
   logic [3:0]  key_ba7_4;
   logic        key_br_w;
   logic        key_d;
   logic        busy;
   logic        done;
   logic        pass;
   logic        err;
   logic [15:0] resp;

   int total;
   int bad;

   key_unlock_sequencer #(
      .MAX_STEPS   (16),
      .GNT_TIMEOUT (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .num_steps   (num_steps),
      .nib_seq     (nib_seq),
      .expect_bits (expect_bits),
      .bus_req     (bus_req),
      .bus_gnt     (bus_gnt),
      .key_sser    (key_sser),
      .key_ba13    (key_ba13),
      .key_ba12    (key_ba12),
      .key_ba7_4   (key_ba7_4),
      .key_br_w    (key_br_w),
      .key_d       (key_d),
      .busy        (busy),
      .done        (done),
      .pass        (pass),
      .err         (err),
      .resp        (resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Key PAL model: state accumulates the nibble while selected, clears when deselected.
   logic [3:0] kst;
   always @(posedge clk) begin
      if (!key_sser && !key_ba13 && key_ba12 && key_br_w) kst <= kst + key_ba7_4;
      else kst <= 4'h0;
   end
   assign key_d = ^kst;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   typedef struct {
      string       name;
      int          num;
      logic [63:0] nibs;
      logic [15:0] exp_bits;
      int          gnt_dly;   // grant raised this many edges after the accepting edge
      int          drop_step; // burst step on which grant is dropped, -1 for none
      logic        exp_pass;
      logic        exp_err;
      logic [15:0] exp_resp;
      int          exp_lat;   // edges from the accepting edge until done is seen
      int          exp_sel;   // cycles with the key selected
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v);
      int   lat;
      int   sel_cnt;
      int   drop_k;
      bit   got_done;
      bit   drv_ok;
      num_steps   = 5'(v.num);
      nib_seq     = v.nibs;
      expect_bits = v.exp_bits;
      bus_gnt     = 1'b0;
      start       = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      drop_k   = (v.drop_step >= 0) ? v.gnt_dly + 2 + v.drop_step : -1;
      lat      = 0;
      sel_cnt  = 0;
      got_done = 1'b0;
      drv_ok   = 1'b1;
      if (v.gnt_dly == 0) bus_gnt = 1'b1;
      while (!got_done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
         start = (lat == 1);   // must be ignored while busy
         if (lat == v.gnt_dly) bus_gnt = 1'b1;
         if (lat == drop_k) bus_gnt = 1'b0;
         #1;
         if (lat == drop_k) check({v.name, " drop_desel"}, 64'(key_sser), 64'd1);
         if (!key_sser) begin
            if (sel_cnt >= 16 || key_ba13 !== 1'b0 || key_ba12 !== 1'b1 || key_br_w !== 1'b1 ||
                key_ba7_4 !== v.nibs[4*sel_cnt +: 4]) drv_ok = 1'b0;
            sel_cnt++;
         end
         if (done === 1'b1) got_done = 1'b1;
      end
      start = 1'b0;
      check({v.name, " done_seen"}, 64'(got_done), 64'd1);
      check({v.name, " latency"}, 64'(lat), 64'(v.exp_lat));
      check({v.name, " pass"}, 64'(pass), 64'(v.exp_pass));
      check({v.name, " err"}, 64'(err), 64'(v.exp_err));
      check({v.name, " resp"}, 64'(resp), 64'(v.exp_resp));
      check({v.name, " sel_cycles"}, 64'(sel_cnt), 64'(v.exp_sel));
      check({v.name, " sel_drive"}, 64'(drv_ok), 64'd1);
      check({v.name, " fin_bus_req"}, 64'(bus_req), 64'd0);
      check({v.name, " fin_busy"}, 64'(busy), 64'd1);
      bus_gnt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check({v.name, " idle_busy"}, 64'(busy), 64'd0);
      check({v.name, " idle_done"}, 64'(done), 64'd0);
      check({v.name, " hold"}, {45'd0, pass, err, resp}, {45'd0, v.exp_pass, v.exp_err, v.exp_resp});
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      rst         = 1'b1;
      start       = 1'b0;
      num_steps   = '0;
      nib_seq     = '0;
      expect_bits = '0;
      bus_gnt     = 1'b0;

      vecs[0] = '{"normal",    4,  64'h8A92, 16'h0006, 2,    -1, 1'b1, 1'b0, 16'h0006, 8,  4};
      vecs[1] = '{"mismatch",  4,  64'h8A92, 16'h0002, 2,    -1, 1'b0, 1'b0, 16'h0006, 8,  4};
      vecs[2] = '{"zero",      0,  64'h8A92, 16'h0000, 2,    -1, 1'b1, 1'b0, 16'h0000, 4,  0};
      vecs[3] = '{"timeout",   4,  64'h8A92, 16'h0006, 1000, -1, 1'b0, 1'b1, 16'h0000, 8,  0};
      vecs[4] = '{"gnt_last",  1,  64'h5,    16'h0001, 7,    -1, 1'b0, 1'b0, 16'h0000, 10, 1};
      vecs[5] = '{"gnt_late",  1,  64'h5,    16'h0001, 8,    -1, 1'b0, 1'b1, 16'h0000, 8,  0};
      vecs[6] = '{"gnt_drop",  6,  64'hC58A92, 16'h0002, 2,   2, 1'b0, 1'b1, 16'h0002, 7,  2};
      vecs[7] = '{"clamp",     20, 64'h1111_1111_1111_1111, 16'h6996, 0, -1, 1'b1, 1'b0, 16'h6996, 18, 16};

      repeat (3) @(posedge clk);
      #1;
      check("rst bus_req", 64'(bus_req), 64'd0);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst pass_err", {62'd0, pass, err}, 64'd0);
      check("rst resp", 64'(resp), 64'd0);
      check("rst key_drive", {56'd0, key_sser, key_ba13, key_ba12, key_br_w, key_ba7_4}, 64'hC0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Reset in the middle of a burst: everything returns to reset values on the next edge.
      num_steps   = 5'd4;
      nib_seq     = 64'h8A92;
      expect_bits = 16'h0006;
      start       = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      bus_gnt = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst in_burst", {62'd0, busy, key_sser}, 64'd2);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst bus_req", 64'(bus_req), 64'd0);
      check("midrst key_sser", 64'(key_sser), 64'd1);
      check("midrst resp", 64'(resp), 64'd0);
      rst     = 1'b0;
      bus_gnt = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("midrst stays_idle", {62'd0, busy, bus_req}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
